alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, registered ALU for the next-generation nopCPU datapath. It keeps the existing eight opcodes at their existing encodings and adds six new ones: left shift, add/subtract with carry, compare, rotate, and a multi-cycle multiply. It also adds a registered N/V/C/Z flag set and a valid/ready input handshake. It sits between the register file read ports and the writeback mux; the control FSM issues operations and consumes `out_valid` pulses.

## Interface
- `WIDTH`, default 8: operand/result width, legal range 4..32.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept; an operation is accepted on a rising edge with `in_valid & in_ready`.
- `opcode`  in  4  operation select.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B / shift count.
- `out_valid`  out  1  one-cycle pulse: `y`, `flags` and `illegal` are updated.
- `y`  out  WIDTH  registered result.
- `flags`  out  4  registered `{N,V,C,Z}`.
- `illegal`  out  1  high with `out_valid` when the opcode was unused.

## Operation
- Opcodes:
  - 0 OR; 1 AND; 2 NOTA (~a); 3 XOR; 4 ADD; 5 SUB (a-b); 6 TX (y=b); 7 RSHIFTN (logical a>>b).
  - 8 LSHIFTN (a<<b); 9 ADC (a+b+C); A SBB (a-b-C); B CMP (flags from a-b, y=a).
  - C ROTR (rotate a right by b mod WIDTH); D MUL (unsigned, low WIDTH bits); E/F illegal.
- ADC and SBB use the currently registered C flag.
- Arithmetic is computed at WIDTH+1 bits; `y` takes the low WIDTH bits.
- Flag updates:
  - Z = (y==0) and N = y[WIDTH-1], for every legal op except CMP, where Z and N come from a-b.
  - ADD/ADC: C = carry out; V = signed overflow.
  - SUB/SBB/CMP: C = borrow (1 when a < b + Cin, unsigned); V = signed overflow.
  - RSHIFTN/LSHIFTN with b in 1..WIDTH-1: C = last bit shifted out (a[b-1] for right, a[WIDTH-b] for left). b==0: y=a, C=0. b>=WIDTH: y=0, C=0. V=0 in all shift cases.
  - OR/AND/NOTA/XOR/TX/ROTR: V=0, C unchanged.
  - MUL: C = V = (high WIDTH bits of the product != 0).
- Illegal opcode: y=0, flags unchanged, `illegal`=1.
- States:
  - IDLE: `in_ready`=1. Accepting a single-cycle op keeps the state IDLE and registers the result. Accepting MUL latches a and b and goes to BUSY with counter=0.
  - BUSY: `in_ready`=0. One shift-add step per cycle, counter increments. After step WIDTH-1, the result is registered, `out_valid` pulses and the state returns to IDLE.
- No output backpressure. The consumer must take `y` on the cycle `out_valid` is high; `y` and `flags` then hold until the next result.

## Timing
- Reset (`rst` high at an edge):
  - y=0, flags=0, out_valid=0, illegal=0, state=IDLE, counter=0.
  - `in_ready`=0 while `rst` is high, and 1 in the first cycle after release.
- Single-cycle ops: `out_valid` is high the cycle after acceptance. Throughput is 1 op per cycle; back-to-back ops produce consecutive `out_valid` pulses in issue order.
- MUL: accepted at edge t; `in_ready` is low for cycles t+1..t+WIDTH; `out_valid` is high in cycle t+WIDTH+1.
- `in_ready` is 1 in the `out_valid` cycle, so a new op may be accepted on that cycle's closing edge.
- `in_valid` while BUSY is ignored; the request is neither dropped silently nor queued, and the issuer must hold it.
- Reset mid-MUL: the operation aborts with no `out_valid`; reset values apply.
- ADC/SBB issued immediately after a flag-producing op use the C produced by that op. Flags are forwarded by the register, with no extra cycle.

## Test plan
- ADD a=0xFF, b=0x01 -> next cycle out_valid=1, y=0x00, Z=1, C=1, V=0. Following ADC a=0x10, b=0x20 -> y=0x31, C=0.
- SUB 0x80-0x01 -> y=0x7F, V=1, C=0, N=0. CMP a=0x05, b=0x07 -> y=0x05, N=1, C=1, Z=0, V=0.
- Shifts on a=0x96:
  - RSHIFTN b=3 -> y=0x12, C=1.
  - LSHIFTN b=8 -> y=0x00, C=0, Z=1.
  - ROTR b=4 -> y=0x69, C unchanged.
- MUL 0x0C×0x0B -> in_ready low 8 cycles, out_valid at t+9, y=0x84, C=V=0.
- MUL 0x20×0x10 -> y=0x00, Z=1, C=V=1.
- OR, AND, XOR, TX issued on 4 consecutive cycles -> out_valid high 4 consecutive cycles with results in order.
- `rst` at cycle 4 of a MUL -> no out_valid, y=0, flags=0, in_ready=1 the cycle after release.
- Opcode 0xE -> out_valid=1, illegal=1, y=0, flags unchanged.

Source files
------------

// File: rtl/alu_seq.sv
// Registered ALU with N/V/C/Z flags, valid/ready input handshake and a
// WIDTH-cycle shift-add multiplier. Single-cycle ops answer on the next cycle.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       flags,
    output logic             illegal
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] W_VAL    = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    localparam logic [3:0] OP_OR   = 4'h0;
    localparam logic [3:0] OP_AND  = 4'h1;
    localparam logic [3:0] OP_NOTA = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_TX   = 4'h6;
    localparam logic [3:0] OP_RSH  = 4'h7;
    localparam logic [3:0] OP_LSH  = 4'h8;
    localparam logic [3:0] OP_ADC  = 4'h9;
    localparam logic [3:0] OP_SBB  = 4'hA;
    localparam logic [3:0] OP_CMP  = 4'hB;
    localparam logic [3:0] OP_ROTR = 4'hC;
    localparam logic [3:0] OP_MUL  = 4'hD;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [3:0]         flags_q, flags_d;
    logic               out_valid_q, out_valid_d;
    logic               illegal_q, illegal_d;

    logic               accept;
    logic               c_in;
    logic [WIDTH:0]     sum_ext, diff_ext;
    logic               add_v, sub_v;
    logic               sh_zero, sh_big;
    logic [WIDTH-1:0]   rmask, lmask, rot_amt;
    logic [WIDTH-1:0]   alu_y;
    logic [3:0]         alu_flags;
    logic               alu_illegal;
    logic               alu_v, alu_c;
    logic [2*WIDTH-1:0] prod_step;
    logic               mul_hi_nz;

    assign accept = in_valid & in_ready;
    assign c_in   = flags_q[1];

    // State register
    // NOTE: every flop below is written with <= so all registers update from
    // the same pre-edge values; blocking = here would create ordering races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
            y_q         <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            prod_q      <= prod_d;
            y_q         <= y_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: defaulting every comb output first guarantees no path leaves
        // it unassigned, which is what would otherwise infer a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept && opcode == OP_MUL) state_d = BUSY;
            BUSY: if (cnt_q == CNT_LAST)          state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: ready is masked by reset so nothing is accepted during it
    always_comb begin
        in_ready = (state_q == IDLE) && !rst;
    end

    // Single-cycle ALU
    always_comb begin
        sum_ext  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (opcode == OP_ADC) & c_in};
        diff_ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, (opcode == OP_SBB) & c_in};
        add_v    = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
        sub_v    = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
        sh_zero  = (b == '0);
        sh_big   = (b >= W_VAL);
        // Masks select the last bit shifted out: a[b-1] right, a[WIDTH-b] left
        rmask    = ONE << (b - ONE);
        lmask    = ONE << (W_VAL - b);
        rot_amt  = b % W_VAL;

        alu_y       = '0;
        alu_v       = 1'b0;
        alu_c       = c_in;
        alu_illegal = 1'b0;

        case (opcode)
            OP_OR:   alu_y = a | b;
            OP_AND:  alu_y = a & b;
            OP_NOTA: alu_y = ~a;
            OP_XOR:  alu_y = a ^ b;
            OP_TX:   alu_y = b;
            OP_ADD, OP_ADC: begin
                alu_y = sum_ext[WIDTH-1:0];
                alu_c = sum_ext[WIDTH];
                alu_v = add_v;
            end
            OP_SUB, OP_SBB: begin
                alu_y = diff_ext[WIDTH-1:0];
                alu_c = diff_ext[WIDTH];
                alu_v = sub_v;
            end
            OP_CMP: begin
                alu_y = a;
                alu_c = diff_ext[WIDTH];
                alu_v = sub_v;
            end
            OP_RSH: begin
                alu_c = 1'b0;
                if (sh_zero)     alu_y = a;
                else if (!sh_big) begin
                    alu_y = a >> b;
                    alu_c = |(a & rmask);
                end
            end
            OP_LSH: begin
                alu_c = 1'b0;
                if (sh_zero)     alu_y = a;
                else if (!sh_big) begin
                    alu_y = a << b;
                    alu_c = |(a & lmask);
                end
            end
            OP_ROTR: alu_y = (a >> rot_amt) | (a << (W_VAL - rot_amt));
            default: alu_illegal = 1'b1;
        endcase

        if (alu_illegal)
            alu_flags = flags_q;
        else if (opcode == OP_CMP)
            alu_flags = {diff_ext[WIDTH-1], alu_v, alu_c, diff_ext[WIDTH-1:0] == '0};
        else
            alu_flags = {alu_y[WIDTH-1], alu_v, alu_c, alu_y == '0};
    end

    // Datapath: result registers and the shift-add multiplier
    always_comb begin
        prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
        mul_hi_nz = |prod_step[2*WIDTH-1:WIDTH];

        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        prod_d      = prod_q;
        y_d         = y_q;
        flags_d     = flags_q;
        illegal_d   = illegal_q;
        out_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (opcode == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                        prod_d   = '0;
                        cnt_d    = '0;
                    end else begin
                        y_d         = alu_y;
                        flags_d     = alu_flags;
                        illegal_d   = alu_illegal;
                        out_valid_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                prod_d   = prod_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    y_d         = prod_step[WIDTH-1:0];
                    flags_d     = {prod_step[WIDTH-1], mul_hi_nz, mul_hi_nz,
                                   prod_step[WIDTH-1:0] == '0};
                    illegal_d   = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign flags     = flags_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): directed ops push expected results,
// a negedge monitor pops and compares on every out_valid pulse.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   opcode;
    logic [W-1:0] a, b;
    logic         out_valid;
    logic [W-1:0] y;
    logic [3:0]   flags;
    logic         illegal;

    typedef struct {
        logic [W-1:0] y;
        logic [3:0]   f;
        logic         ill;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .a(a), .b(b), .out_valid(out_valid),
        .y(y), .flags(flags), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out_valid: got y=0x%0h with nothing outstanding", y);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, ".y"}, 32'(y), 32'(e.y));
                check({e.name, ".flags"}, 32'(flags), 32'(e.f));
                check({e.name, ".illegal"}, 32'(illegal), 32'(e.ill));
            end
        end
    end

    // Presents one op and returns 1 time unit after the edge that accepted it
    task automatic issue(input logic [3:0] op, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic push, input logic [W-1:0] ey, input logic [3:0] ef,
                         input logic eill, input string name);
        int waited = 0;
        exp_t e;
        in_valid = 1'b1;
        opcode   = op;
        a        = va;
        b        = vb;
        while (in_ready !== 1'b1 && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (in_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s.accept_timeout: got in_ready=%b expected 1", name, in_ready);
        end
        if (push) begin
            e.y = ey; e.f = ef; e.ill = eill; e.name = name;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        opcode   = '0;
        a        = '0;
        b        = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready", 32'(in_ready), 0);
        check("rst.y", 32'(y), 0);
        check("rst.flags", 32'(flags), 0);
        check("rst.out_valid", 32'(out_valid), 0);
        check("rst.illegal", 32'(illegal), 0);
        rst = 1'b0;
        #1;
        check("rst_release.in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;

        // Arithmetic with carry chaining through the flag register
        issue(4'h4, 8'hFF, 8'h01, 1, 8'h00, 4'b0011, 0, "add_ff_01");
        check("add.out_valid_next", 32'(out_valid), 1);
        issue(4'h9, 8'h10, 8'h20, 1, 8'h31, 4'b0000, 0, "adc_chain");
        issue(4'h5, 8'h80, 8'h01, 1, 8'h7F, 4'b0100, 0, "sub_80_01");
        issue(4'hB, 8'h05, 8'h07, 1, 8'h05, 4'b1010, 0, "cmp_05_07");
        issue(4'hA, 8'h10, 8'h05, 1, 8'h0A, 4'b0000, 0, "sbb_borrow_in");
        // Shifts and rotate on 0x96
        issue(4'h7, 8'h96, 8'd3, 1, 8'h12, 4'b0010, 0, "rsh_3");
        issue(4'hC, 8'h96, 8'd4, 1, 8'h69, 4'b0010, 0, "rotr_4_keep_c");
        issue(4'h8, 8'h96, 8'd8, 1, 8'h00, 4'b0001, 0, "lsh_8");
        issue(4'h8, 8'h96, 8'd3, 1, 8'hB0, 4'b1000, 0, "lsh_3");
        issue(4'hE, 8'h12, 8'h34, 1, 8'h00, 4'b1000, 1, "illegal_e");
        idle_cycle();
        idle_cycle();

        // Multi-cycle multiply with handshake timing
        issue(4'hD, 8'h0C, 8'h0B, 1, 8'h84, 4'b1000, 0, "mul_0c_0b");
        in_valid = 1'b0;
        for (int k = 1; k <= W; k++) begin
            check($sformatf("mul.busy_cycle%0d.in_ready", k), 32'(in_ready), 0);
            check($sformatf("mul.busy_cycle%0d.out_valid", k), 32'(out_valid), 0);
            @(posedge clk);
            #1;
        end
        check("mul.done.out_valid", 32'(out_valid), 1);
        check("mul.done.in_ready", 32'(in_ready), 1);
        // Issued on the out_valid cycle: accepted on its closing edge
        issue(4'hD, 8'h20, 8'h10, 1, 8'h00, 4'b0111, 0, "mul_20_10");
        in_valid = 1'b0;
        repeat (W) @(posedge clk);
        #1;
        check("mul2.done.out_valid", 32'(out_valid), 1);

        // Back-to-back logic ops: one pulse per cycle, in order
        issue(4'h0, 8'hC3, 8'h5A, 1, 8'hDB, 4'b1010, 0, "or_b2b");
        check("b2b.pulse1", 32'(out_valid), 1);
        issue(4'h1, 8'hC3, 8'h5A, 1, 8'h42, 4'b0010, 0, "and_b2b");
        check("b2b.pulse2", 32'(out_valid), 1);
        issue(4'h3, 8'hC3, 8'h5A, 1, 8'h99, 4'b1010, 0, "xor_b2b");
        check("b2b.pulse3", 32'(out_valid), 1);
        issue(4'h6, 8'hC3, 8'h5A, 1, 8'h5A, 4'b0010, 0, "tx_b2b");
        check("b2b.pulse4", 32'(out_valid), 1);
        idle_cycle();
        check("b2b.after", 32'(out_valid), 0);

        // Reset during a multiply: aborted, no result
        issue(4'hD, 8'h0C, 8'h0B, 0, 8'h00, 4'b0000, 0, "mul_abort");
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort.rst.in_ready", 32'(in_ready), 0);
        check("abort.y", 32'(y), 0);
        check("abort.flags", 32'(flags), 0);
        rst = 1'b0;
        #1;
        check("abort.release.in_ready", 32'(in_ready), 1);
        for (int k = 0; k < W + 3; k++) begin
            @(posedge clk);
            #1;
            check("abort.no_out_valid", 32'(out_valid), 0);
        end

        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
